// File: rtl/alu_rs_scheduler.sv
// Reservation station for the integer ALU: buffers dispatched ops, snoops the CDB
// for pending operands and issues the lowest-index ready entry each cycle.

module alu_rs_entry #(
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear,
   input  logic                 alloc,
   input  logic                 issue,
   input  logic [3:0]           in_op,
   input  logic [31:0]          in_vj,
   input  logic [31:0]          in_vk,
   input  logic                 in_qj_valid,
   input  logic                 in_qk_valid,
   input  logic [ROB_WIDTH-1:0] in_qj,
   input  logic [ROB_WIDTH-1:0] in_qk,
   input  logic [ROB_WIDTH-1:0] in_rob,
   input  logic                 cdb_valid,
   input  logic [ROB_WIDTH-1:0] cdb_rob,
   input  logic [31:0]          cdb_value,
   output logic                 busy,
   output logic                 ready,
   output logic [3:0]           op,
   output logic [31:0]          vj,
   output logic [31:0]          vk,
   output logic [ROB_WIDTH-1:0] rob
);
   logic                 qj_valid, qk_valid;
   logic [ROB_WIDTH-1:0] qj, qk;
   logic                 fwd_j, fwd_k, snp_j, snp_k;

   // Dispatch-time forwarding covers a tag broadcast in the same cycle it is allocated.
   assign fwd_j = in_qj_valid && cdb_valid && (cdb_rob == in_qj);
   assign fwd_k = in_qk_valid && cdb_valid && (cdb_rob == in_qk);
   assign snp_j = busy && qj_valid && cdb_valid && (cdb_rob == qj);
   assign snp_k = busy && qk_valid && cdb_valid && (cdb_rob == qk);
   assign ready = busy && !qj_valid && !qk_valid;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         busy     <= 1'b0;
         op       <= '0;
         vj       <= '0;
         vk       <= '0;
         qj_valid <= 1'b0;
         qk_valid <= 1'b0;
         qj       <= '0;
         qk       <= '0;
         rob      <= '0;
      end else if (rdy_in) begin
         if (clear) begin
            busy <= 1'b0;
         end else if (alloc) begin
            busy     <= 1'b1;
            op       <= in_op;
            rob      <= in_rob;
            qj       <= in_qj;
            qk       <= in_qk;
            qj_valid <= in_qj_valid && !fwd_j;
            qk_valid <= in_qk_valid && !fwd_k;
            vj       <= fwd_j ? cdb_value : in_vj;
            vk       <= fwd_k ? cdb_value : in_vk;
         end else begin
            if (issue) busy <= 1'b0;
            if (snp_j) begin
               vj       <= cdb_value;
               qj_valid <= 1'b0;
            end
            if (snp_k) begin
               vk       <= cdb_value;
               qk_valid <= 1'b0;
            end
         end
      end
   end
endmodule

module alu_rs_scheduler #(
   parameter int ROB_WIDTH = 4,
   parameter int RS_WIDTH  = 3
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear,
   input  logic                 in_valid,
   input  logic [3:0]           in_op,
   input  logic [31:0]          in_vj,
   input  logic [31:0]          in_vk,
   input  logic                 in_qj_valid,
   input  logic                 in_qk_valid,
   input  logic [ROB_WIDTH-1:0] in_qj,
   input  logic [ROB_WIDTH-1:0] in_qk,
   input  logic [ROB_WIDTH-1:0] in_rob,
   output logic                 full,
   input  logic                 cdb_valid,
   input  logic [ROB_WIDTH-1:0] cdb_rob,
   input  logic [31:0]          cdb_value,
   output logic                 issue_cal,
   output logic [31:0]          issue_a,
   output logic [31:0]          issue_b,
   output logic [3:0]           issue_op,
   output logic [ROB_WIDTH-1:0] issue_rob
);
   localparam int RS_SIZE = 2 ** RS_WIDTH;

   typedef struct packed {
      logic [3:0]           op;
      logic [31:0]          a;
      logic [31:0]          b;
      logic [ROB_WIDTH-1:0] rob;
   } iss_t;

   logic [RS_SIZE-1:0]                busy, ready, free_oh, alloc_oh, issue_oh;
   logic [RS_SIZE-1:0][3:0]           e_op;
   logic [RS_SIZE-1:0][31:0]          e_vj, e_vk;
   logic [RS_SIZE-1:0][ROB_WIDTH-1:0] e_rob;
   logic [RS_WIDTH-1:0]               issue_idx;
   iss_t                              iss_d, iss_q;

   assign full = &busy;

   // Lowest clear bit of busy / lowest set bit of ready, as one-hot masks.
   assign free_oh  = ~busy & (busy + 1'b1);
   assign alloc_oh = (in_valid && !full) ? free_oh : '0;
   assign issue_oh = ready & (~ready + 1'b1);

   always_comb begin
      issue_idx = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--)
         if (ready[i]) issue_idx = RS_WIDTH'(i);
   end

   assign iss_d = '{op: e_op[issue_idx], a: e_vj[issue_idx], b: e_vk[issue_idx], rob: e_rob[issue_idx]};

   for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
      alu_rs_entry #(.ROB_WIDTH(ROB_WIDTH)) u_ent (
         .clk_in     (clk_in),
         .rst_in     (rst_in),
         .rdy_in     (rdy_in),
         .clear      (clear),
         .alloc      (alloc_oh[g]),
         .issue      (issue_oh[g]),
         .in_op      (in_op),
         .in_vj      (in_vj),
         .in_vk      (in_vk),
         .in_qj_valid(in_qj_valid),
         .in_qk_valid(in_qk_valid),
         .in_qj      (in_qj),
         .in_qk      (in_qk),
         .in_rob     (in_rob),
         .cdb_valid  (cdb_valid),
         .cdb_rob    (cdb_rob),
         .cdb_value  (cdb_value),
         .busy       (busy[g]),
         .ready      (ready[g]),
         .op         (e_op[g]),
         .vj         (e_vj[g]),
         .vk         (e_vk[g]),
         .rob        (e_rob[g])
      );
   end

   // Data outputs hold when nothing issues; only the request strobe drops.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         issue_cal <= 1'b0;
         iss_q     <= '0;
      end else if (rdy_in) begin
         if (clear) begin
            issue_cal <= 1'b0;
         end else begin
            issue_cal <= |ready;
            if (|ready) iss_q <= iss_d;
         end
      end
   end

   assign issue_a   = iss_q.a;
   assign issue_b   = iss_q.b;
   assign issue_op  = iss_q.op;
   assign issue_rob = iss_q.rob;
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: directed vector table, hand-written corner sequences,
// then random traffic compared against an entry-array reference model.

module tb_alu_rs_scheduler;
   logic        clk_in, rst_in, rdy_in, clear, in_valid;
   logic [3:0]  in_op, in_qj, in_qk, in_rob, cdb_rob, issue_op, issue_rob;
   logic [31:0] in_vj, in_vk, cdb_value, issue_a, issue_b;
   logic        in_qj_valid, in_qk_valid, cdb_valid, full, issue_cal;

   int n_cmp = 0;
   int n_bad = 0;

   alu_rs_scheduler #(.ROB_WIDTH(4), .RS_WIDTH(3)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
      .in_valid(in_valid), .in_op(in_op), .in_vj(in_vj), .in_vk(in_vk),
      .in_qj_valid(in_qj_valid), .in_qk_valid(in_qk_valid), .in_qj(in_qj),
      .in_qk(in_qk), .in_rob(in_rob), .full(full), .cdb_valid(cdb_valid),
      .cdb_rob(cdb_rob), .cdb_value(cdb_value), .issue_cal(issue_cal),
      .issue_a(issue_a), .issue_b(issue_b), .issue_op(issue_op), .issue_rob(issue_rob)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Reference model: 8 slots, lowest free slot allocates, lowest ready slot issues.
   logic        m_busy[8], m_qjv[8], m_qkv[8];
   logic [3:0]  m_qj[8], m_qk[8], m_op[8], m_rob[8];
   logic [31:0] m_vj[8], m_vk[8];
   logic        m_cal;
   logic [31:0] m_a, m_b;
   logic [3:0]  m_iop, m_irob;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      m_cal = 1'b0; m_a = '0; m_b = '0; m_iop = '0; m_irob = '0;
   endtask

   function automatic logic model_full();
      for (int i = 0; i < 8; i++) if (!m_busy[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step();
      int r = -1;
      int f = -1;
      if (!rdy_in) return;
      if (clear) begin
         for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
         m_cal = 1'b0;
         return;
      end
      for (int i = 7; i >= 0; i--) begin
         if (m_busy[i] && !m_qjv[i] && !m_qkv[i]) r = i;
         if (!m_busy[i]) f = i;
      end
      m_cal = (r >= 0);
      if (r >= 0) begin
         m_a = m_vj[r]; m_b = m_vk[r]; m_iop = m_op[r]; m_irob = m_rob[r];
      end
      if (cdb_valid)
         for (int i = 0; i < 8; i++) if (m_busy[i]) begin
            if (m_qjv[i] && m_qj[i] == cdb_rob) begin m_vj[i] = cdb_value; m_qjv[i] = 1'b0; end
            if (m_qkv[i] && m_qk[i] == cdb_rob) begin m_vk[i] = cdb_value; m_qkv[i] = 1'b0; end
         end
      if (r >= 0) m_busy[r] = 1'b0;
      if (in_valid && f >= 0) begin
         m_busy[f] = 1'b1; m_op[f] = in_op; m_rob[f] = in_rob;
         m_qj[f] = in_qj; m_qk[f] = in_qk;
         m_qjv[f] = in_qj_valid; m_qkv[f] = in_qk_valid;
         m_vj[f] = in_vj; m_vk[f] = in_vk;
         if (in_qj_valid && cdb_valid && cdb_rob == in_qj) begin m_vj[f] = cdb_value; m_qjv[f] = 1'b0; end
         if (in_qk_valid && cdb_valid && cdb_rob == in_qk) begin m_vk[f] = cdb_value; m_qkv[f] = 1'b0; end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic cal, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] op,
                            input logic [3:0] rob, input logic fl);
      check({name, "_cal"}, issue_cal, cal);
      check({name, "_a"}, issue_a, a);
      check({name, "_b"}, issue_b, b);
      check({name, "_op"}, issue_op, op);
      check({name, "_rob"}, issue_rob, rob);
      check({name, "_full"}, full, fl);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [3:0] op, input logic [31:0] vj,
                        input logic [31:0] vk, input logic qjv, input logic [3:0] qj,
                        input logic qkv, input logic [3:0] qk, input logic [3:0] rob);
      in_valid = iv; in_op = op; in_vj = vj; in_vk = vk;
      in_qj_valid = qjv; in_qj = qj; in_qk_valid = qkv; in_qk = qk; in_rob = rob;
   endtask

   task automatic cdb(input logic v, input logic [3:0] t, input logic [31:0] val);
      cdb_valid = v; cdb_rob = t; cdb_value = val;
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
      cdb(1'b0, 4'd0, 32'd0);
      rdy_in = 1'b1; clear = 1'b0;
   endtask

   typedef struct {
      logic        iv;  logic [3:0] op;  logic [31:0] vj, vk;
      logic        qjv; logic [3:0] qj;  logic qkv; logic [3:0] qk; logic [3:0] rob;
      logic        cv;  logic [3:0] crob; logic [31:0] cval;
      logic        e_cal; logic [31:0] e_a, e_b; logic [3:0] e_op, e_rob; logic e_full;
   } vec_t;

   vec_t tbl[10];

   initial begin
      // dispatch / CDB inputs | expected issue outputs after the edge
      tbl[0] = '{1'b1, 4'h0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 1'b0, 4'd0, 32'h0,  1'b0, 32'h0,  32'h0,  4'h0, 4'd0, 1'b0};
      tbl[1] = '{1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0,  1'b1, 32'd5,  32'd7,  4'h0, 4'd1, 1'b0};
      tbl[2] = '{1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0,  1'b0, 32'd5,  32'd7,  4'h0, 4'd1, 1'b0};
      tbl[3] = '{1'b1, 4'h3, 32'd0, 32'd2, 1'b1, 4'd3, 1'b0, 4'd0, 4'd2, 1'b0, 4'd0, 32'h0,  1'b0, 32'd5,  32'd7,  4'h0, 4'd1, 1'b0};
      tbl[4] = '{1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0,  1'b0, 32'd5,  32'd7,  4'h0, 4'd1, 1'b0};
      tbl[5] = '{1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd3, 32'h10, 1'b0, 32'd5,  32'd7,  4'h0, 4'd1, 1'b0};
      tbl[6] = '{1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0,  1'b1, 32'h10, 32'd2,  4'h3, 4'd2, 1'b0};
      tbl[7] = '{1'b1, 4'h5, 32'd9, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd4, 1'b1, 4'd6, 32'hFF, 1'b0, 32'h10, 32'd2,  4'h3, 4'd2, 1'b0};
      tbl[8] = '{1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0,  1'b1, 32'd9,  32'hFF, 4'h5, 4'd4, 1'b0};
      tbl[9] = '{1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0,  1'b0, 32'd9,  32'hFF, 4'h5, 4'd4, 1'b0};

      idle();
      rst_in = 1'b1;
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      check_out("reset", 1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0);
      rst_in = 1'b0;
      @(posedge clk_in);
      #1;
      check_out("post_reset", 1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].iv, tbl[i].op, tbl[i].vj, tbl[i].vk, tbl[i].qjv, tbl[i].qj,
               tbl[i].qkv, tbl[i].qk, tbl[i].rob);
         cdb(tbl[i].cv, tbl[i].crob, tbl[i].cval);
         tick();
         check_out($sformatf("vec%0d", i), tbl[i].e_cal, tbl[i].e_a, tbl[i].e_b,
                   tbl[i].e_op, tbl[i].e_rob, tbl[i].e_full);
      end

      // Fill: slot i waits on tag i, except slot 6 which shares tag 2 with slot 2.
      for (int i = 0; i < 8; i++) begin
         idle();
         drive(1'b1, 4'(i), 32'd0, 32'h100 + 32'(i), 1'b1, (i == 6) ? 4'd2 : 4'(i), 1'b0, 4'd0, 4'(i));
         tick();
      end
      idle();
      check_out("filled", 1'b0, 32'd9, 32'hFF, 4'h5, 4'd4, 1'b1);
      drive(1'b1, 4'hF, 32'hAA, 32'hBB, 1'b0, 4'd0, 1'b0, 4'd0, 4'hF);
      tick();
      idle();
      check_out("drop9", 1'b0, 32'd9, 32'hFF, 4'h5, 4'd4, 1'b1);
      tick();
      check_out("drop9_idle", 1'b0, 32'd9, 32'hFF, 4'h5, 4'd4, 1'b1);
      cdb(1'b1, 4'd5, 32'h55);
      tick();
      idle();
      check_out("wake5", 1'b0, 32'd9, 32'hFF, 4'h5, 4'd4, 1'b1);
      tick();
      check_out("issue5", 1'b1, 32'h55, 32'h105, 4'd5, 4'd5, 1'b0);

      // Slots 2 and 6 wake together; lower index goes first.
      cdb(1'b1, 4'd2, 32'h22);
      tick();
      idle();
      check_out("wake2_6", 1'b0, 32'h55, 32'h105, 4'd5, 4'd5, 1'b0);
      tick();
      check_out("prio_2", 1'b1, 32'h22, 32'h102, 4'd2, 4'd2, 1'b0);
      tick();
      check_out("prio_6", 1'b1, 32'h22, 32'h106, 4'd6, 4'd6, 1'b0);
      tick();
      check_out("prio_done", 1'b0, 32'h22, 32'h106, 4'd6, 4'd6, 1'b0);

      // Freeze with a ready entry in slot 2, then flush it.
      drive(1'b1, 4'd1, 32'h11, 32'h12, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
      tick();
      check_out("freeze_alloc", 1'b0, 32'h22, 32'h106, 4'd6, 4'd6, 1'b0);
      for (int i = 0; i < 3; i++) begin
         rdy_in = 1'b0;
         cdb(1'b1, 4'd0, 32'h99);
         tick();
         check_out($sformatf("freeze%0d", i), 1'b0, 32'h22, 32'h106, 4'd6, 4'd6, 1'b0);
      end
      rdy_in = 1'b1; clear = 1'b1;
      cdb(1'b1, 4'd1, 32'h77);
      tick();
      idle();
      check_out("clear", 1'b0, 32'h22, 32'h106, 4'd6, 4'd6, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_out($sformatf("post_clear%0d", i), 1'b0, 32'h22, 32'h106, 4'd6, 4'd6, 1'b0);
      end

      // Asynchronous reset in the middle of an issue cycle.
      drive(1'b1, 4'd7, 32'h71, 32'h72, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
      tick();
      idle();
      tick();
      check_out("pre_areset", 1'b1, 32'h71, 32'h72, 4'd7, 4'd3, 1'b0);
      #2;
      rst_in = 1'b1;
      model_reset();
      #1;
      check_out("areset", 1'b0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         rdy_in = ($urandom_range(0, 9) != 0);
         clear  = ($urandom_range(0, 39) == 0);
         drive(($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), $urandom, $urandom,
               ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 7)),
               ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
         cdb(($urandom_range(0, 1) == 1), 4'($urandom_range(0, 7)), $urandom);
         tick();
         check_out($sformatf("rnd%0d", c), m_cal, m_a, m_b, m_iop, m_irob, model_full());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
